// File: rtl/load_store_unit_pkg.sv
// Shared core encodings: decoder opcodes, load/store types, LSU states and bus payload.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUSY = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

  // Byte-lane enables for an access of the given size at a byte offset
  function automatic logic [BE_W-1:0] byte_enables(input access_size_e size,
                                                   input logic [1:0]   offset);
    logic [BE_W-1:0] be;
    case (size)
      SZ_BYTE: be = BE_W'(4'b0001) << offset;
      SZ_HALF: be = BE_W'(4'b0011) << offset;
      default: be = BE_W'(4'b1111);
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword from a bus word and sign/zero-extends it.
module load_align_ext
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] bus_word,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result   = bus_word;
    case (offset)
      2'b00:   byte_sel = bus_word[7:0];
      2'b01:   byte_sel = bus_word[15:8];
      2'b10:   byte_sel = bus_word[23:16];
      default: byte_sel = bus_word[31:24];
    endcase
    half_sel = offset[1] ? bus_word[31:16] : bus_word[15:0];
    case (load_type)
      3'(LT_LB):  result = {{24{byte_sel[7]}}, byte_sel};
      3'(LT_LBU): result = {24'h000000, byte_sel};
      3'(LT_LH):  result = {{16{half_sel[15]}}, half_sel};
      3'(LT_LHU): result = {16'h0000, half_sel};
      default:    result = bus_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding bus access with lane steering,
// misalignment rejection and a bus-ack watchdog.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_load_type,
  input  logic [1:0]      mem_store_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            misaligned,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] wd_cnt;
  bus_cmd_t         cmd_q, cmd_d;
  logic             bus_req_q, is_load_q;
  logic [2:0]       ld_type_q, ld_type_d;
  logic [1:0]       offset_q;
  logic [XLEN-1:0]  rdata_q, ld_result;
  logic             rdata_valid_q, misaligned_q, bus_err_q;
  access_size_e     size_d;
  logic             req_d, misaligned_d;

  // Request decode; a store wins when both strobes are high
  always_comb begin
    req_d     = mem_read | mem_write;
    size_d    = SZ_WORD;
    ld_type_d = 3'(LT_LW);
    if (mem_write) begin
      case (mem_store_type)
        2'(ST_SB): size_d = SZ_BYTE;
        2'(ST_SH): size_d = SZ_HALF;
        default:   size_d = SZ_WORD;
      endcase
    end else begin
      case (mem_load_type)
        3'(LT_LB), 3'(LT_LBU): size_d = SZ_BYTE;
        3'(LT_LH), 3'(LT_LHU): size_d = SZ_HALF;
        default:               size_d = SZ_WORD;
      endcase
      ld_type_d = (mem_load_type > 3'(LT_LHU)) ? 3'(LT_LW) : mem_load_type;
    end
    misaligned_d = ((size_d == SZ_HALF) && addr[0]) ||
                   ((size_d == SZ_WORD) && (addr[1:0] != 2'b00));
    cmd_d.we    = mem_write;
    cmd_d.addr  = {addr[XLEN-1:2], 2'b00};
    cmd_d.be    = byte_enables(size_d, addr[1:0]);
    cmd_d.wdata = '0;
    if (mem_write) begin
      case (size_d)
        SZ_BYTE: cmd_d.wdata = {4{wdata[7:0]}};
        SZ_HALF: cmd_d.wdata = {2{wdata[15:0]}};
        default: cmd_d.wdata = wdata;
      endcase
    end
  end

  load_align_ext u_load_align_ext (
    .bus_word  (bus_rdata),
    .offset    (offset_q),
    .load_type (ld_type_q),
    .result    (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LSU_IDLE;
      wd_cnt        <= '0;
      cmd_q         <= '0;
      bus_req_q     <= 1'b0;
      is_load_q     <= 1'b0;
      ld_type_q     <= '0;
      offset_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_err_q     <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (req_d) begin
            is_load_q <= ~mem_write;
            ld_type_q <= ld_type_d;
            offset_q  <= addr[1:0];
            if (misaligned_d) begin
              misaligned_q <= 1'b1;
              state        <= LSU_DONE;
            end else begin
              cmd_q     <= cmd_d;
              bus_req_q <= 1'b1;
              wd_cnt    <= '0;
              state     <= LSU_BUSY;
            end
          end
        end
        LSU_BUSY: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            cmd_q     <= '0;
            state     <= LSU_DONE;
            if (is_load_q) begin
              rdata_q       <= ld_result;
              rdata_valid_q <= 1'b1;
            end
          end else if (wd_cnt == CNT_LAST) begin
            bus_req_q <= 1'b0;
            cmd_q     <= '0;
            bus_err_q <= 1'b1;
            state     <= LSU_DONE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  // Stall rises in the request cycle itself so the decoder holds the instruction
  assign stall = rst_n & ((state == LSU_BUSY) || ((state == LSU_IDLE) && req_d));

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misaligned  = misaligned_q;
  assign bus_err     = bus_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = cmd_q.we;
  assign bus_addr    = cmd_q.addr;
  assign bus_be      = cmd_q.be;
  assign bus_wdata   = cmd_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected DONE results queued at issue, compared at DONE.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;
  localparam int MAXC    = 700;

  logic        clk, rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, misaligned, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        valid;
    logic        mis;
    logic        err;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic exp_t mk(input logic [31:0] a, input logic [3:0] be, input logic we,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic v, input logic m, input logic e, input int busy);
    exp_t x;
    x.addr = a; x.be = be; x.we = we; x.wdata = wd; x.rdata = rd;
    x.valid = v; x.mis = m; x.err = e; x.busy = busy;
    return x;
  endfunction

  // Reference behaviour for randomised accesses
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] lt,
                                 input logic [1:0] st, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] brd,
                                 input int ack_dly);
    exp_t x;
    int size;
    logic [31:0] lane;
    size = 4;
    if (wr) size = (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : 4;
    else if (lt == 3'b000 || lt == 3'b011) size = 1;
    else if (lt == 3'b001 || lt == 3'b100) size = 2;
    x.addr  = {a[31:2], 2'b00};
    x.we    = wr;
    x.be    = (size == 1) ? (4'b0001 << a[1:0]) : (size == 2) ? (4'b0011 << a[1:0]) : 4'b1111;
    x.wdata = !wr ? 32'h0 : (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
    x.mis   = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
    x.err   = !x.mis && (ack_dly < 0);
    x.valid = rd && !wr && !x.mis && !x.err;
    x.busy  = x.mis ? 0 : (ack_dly < 0 ? TIMEOUT : ack_dly + 1);
    lane    = brd >> (8 * a[1:0]);
    x.rdata = 32'h0;
    if (x.valid) begin
      case (lt)
        3'b000:  x.rdata = {{24{lane[7]}}, lane[7:0]};
        3'b011:  x.rdata = {24'h0, lane[7:0]};
        3'b001:  x.rdata = {{16{lane[15]}}, lane[15:0]};
        3'b100:  x.rdata = {16'h0, lane[15:0]};
        default: x.rdata = brd;
      endcase
    end
    return x;
  endfunction

  task automatic drop_inputs();
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF;
  endtask

  // Issue one access, play the bus side, and check the DONE cycle against the queue head
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] brd, input int ack_dly, input exp_t e,
                           input bit idle_gap, input string tag);
    exp_t x;
    int busy, total;
    bit done;
    sb.push_back(e);
    if (idle_gap) begin
      @(negedge clk);
      n_vec++;
      if (stall !== 1'b0 || rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL %s idle: stall=%b rdata=%h, want stall=0 rdata=0", tag, stall, rdata);
      end
    end
    mem_read = rd; mem_write = wr; mem_load_type = lt; mem_store_type = st;
    addr = a; wdata = wd;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL %s request stall: got %b want 1", tag, stall);
    end
    busy = 0; total = 0; done = 1'b0;
    for (int c = 0; c < MAXC && !done; c++) begin
      @(negedge clk);
      total++;
      if (!stall) begin
        done = 1'b1;
        x = sb.pop_front();
        n_vec++;
        if (rdata !== x.rdata || rdata_valid !== x.valid) begin
          n_bad++;
          $display("FAIL %s rdata: got %h/v%b want %h/v%b", tag, rdata, rdata_valid, x.rdata, x.valid);
        end
        n_vec++;
        if (misaligned !== x.mis || bus_err !== x.err || bus_req !== 1'b0) begin
          n_bad++;
          $display("FAIL %s flags: got mis=%b err=%b req=%b want mis=%b err=%b req=0",
                   tag, misaligned, bus_err, bus_req, x.mis, x.err);
        end
        n_vec++;
        if (busy != x.busy || total != x.busy + 1) begin
          n_bad++;
          $display("FAIL %s latency: got busy=%0d total=%0d want busy=%0d total=%0d",
                   tag, busy, total, x.busy, x.busy + 1);
        end
        drop_inputs();
      end else if (bus_req) begin
        busy++;
        n_vec++;
        if ({bus_we, bus_addr, bus_be, bus_wdata} !== {sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata}) begin
          n_bad++;
          $display("FAIL %s bus: got we=%b a=%h be=%b wd=%h want we=%b a=%h be=%b wd=%h", tag,
                   bus_we, bus_addr, bus_be, bus_wdata, sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata);
        end
        if (busy - 1 == ack_dly) begin
          bus_ack = 1'b1; bus_rdata = brd;
        end else begin
          bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF;
        end
      end
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s no DONE within %0d cycles: got none want DONE", tag, MAXC);
      void'(sb.pop_front());
      drop_inputs();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop_inputs();
    mem_read = 1'b1; mem_load_type = 3'b010; mem_store_type = 2'b00;
    addr = 32'h0000_0100; wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({stall, rdata, rdata_valid, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got stall=%b req=%b be=%b rdata=%h want all 0", stall, bus_req, bus_be, rdata);
    end
    // Release and request in the same cycle: must be taken on the first edge
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 0,
              mk(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF, 1, 0, 0, 1), 1'b0, "first_after_reset");
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1,
              mk(32'h0000_1000, 4'b1000, 1, 32'hABAB_ABAB, 32'h0, 0, 0, 0, 2), 1'b1, "sb_1003");
    do_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_7002, 32'hAAAA_5555, 32'h0, 0,
              mk(32'h0000_7000, 4'b1100, 1, 32'h5555_5555, 32'h0, 0, 0, 0, 1), 1'b1, "sh_7002");
    do_access(1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_7008, 32'h1122_3344, 32'h0, 2,
              mk(32'h0000_7008, 4'b1111, 1, 32'h1122_3344, 32'h0, 0, 0, 0, 3), 1'b1, "st11_as_sw");
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0,
              mk(32'h0000_2000, 4'b0010, 0, 32'h0, 32'hFFFF_FF80, 1, 0, 0, 1), 1'b1, "lb_2001");
    do_access(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_2001, 32'h0, 32'h0000_80FF, 0,
              mk(32'h0000_2000, 4'b0010, 0, 32'h0, 32'h0000_0080, 1, 0, 0, 1), 1'b1, "lbu_2001");
    do_access(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_2002, 32'h0, 32'h8001_0000, 1,
              mk(32'h0000_2000, 4'b1100, 0, 32'h0, 32'hFFFF_8001, 1, 0, 0, 2), 1'b1, "lh_2002");
    do_access(1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_2002, 32'h0, 32'h8001_0000, 0,
              mk(32'h0000_2000, 4'b1100, 0, 32'h0, 32'h0000_8001, 1, 0, 0, 1), 1'b1, "lhu_2002");
    do_access(1'b1, 1'b0, 3'b111, 2'b00, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 3,
              mk(32'h0000_6004, 4'b1111, 0, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 4), 1'b1, "lt111_as_lw");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_3002, 32'h0, 32'h0, 0,
              mk(32'h0, 4'b0, 0, 32'h0, 32'h0, 0, 1, 0, 0), 1'b1, "lw_3002");
    do_access(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_2003, 32'h0, 32'h0, 0,
              mk(32'h0, 4'b0, 0, 32'h0, 32'h0, 0, 1, 0, 0), 1'b1, "lh_2003");
    do_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_7001, 32'h0, 32'h0, 0,
              mk(32'h0, 4'b0, 0, 32'h0, 32'h0, 0, 1, 0, 0), 1'b1, "sh_7001");
  endtask

  task automatic test_priority();
    // LW at this address would be misaligned; the byte store must win
    do_access(1'b1, 1'b1, 3'b010, 2'b00, 32'h0000_8001, 32'h0000_005A, 32'hFFFF_FFFF, 0,
              mk(32'h0000_8000, 4'b0010, 1, 32'h5A5A_5A5A, 32'h0, 0, 0, 0, 1), 1'b1, "rd_wr_both");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h0000_5000, 32'h1234_5678, 32'h0, -1,
              mk(32'h0000_5000, 4'b1111, 1, 32'h1234_5678, 32'h0, 0, 0, 1, TIMEOUT), 1'b1, "sw_timeout");
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({rdata_valid, bus_err, misaligned, bus_req, stall} !== 5'b0 || rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL stray_ack: got v=%b err=%b req=%b stall=%b rdata=%h want all 0",
                 rdata_valid, bus_err, bus_req, stall, rdata);
      end
    end
    drop_inputs();
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    mem_write = 1'b1; mem_store_type = 2'b10; addr = 32'h0000_4000; wdata = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy pre-reset bus_req: got %b want 1", bus_req);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || bus_be !== 4'b0 || bus_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_busy reset: got req=%b stall=%b be=%b addr=%h want 0", bus_req, stall, bus_be, bus_addr);
    end
    @(negedge clk);
    mem_write = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    repeat (2) begin
      @(negedge clk);
      bus_ack = 1'b0;
      n_vec++;
      if ({rdata_valid, bus_err, misaligned, bus_req, stall} !== 5'b0 || rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL late_ack: got v=%b err=%b req=%b stall=%b rdata=%h want all 0",
                 rdata_valid, bus_err, bus_req, stall, rdata);
      end
    end
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_4003, 32'h0, 32'h7F00_0000, 0,
              mk(32'h0000_4000, 4'b1000, 0, 32'h0, 32'h0000_007F, 1, 0, 0, 1), 1'b1, "after_reset_lb");
  endtask

  task automatic test_random();
    logic rd, wr;
    logic [2:0] lt;
    logic [1:0] st;
    logic [31:0] a, wd, brd;
    int dly, kind;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      rd  = (kind != 1);
      wr  = (kind != 0);
      lt  = 3'($urandom_range(0, 7));
      st  = 2'($urandom_range(0, 3));
      a   = $urandom;
      wd  = $urandom;
      brd = $urandom;
      dly = $urandom_range(0, 3);
      do_access(rd, wr, lt, st, a, wd, brd, dly, model(rd, wr, lt, st, a, wd, brd, dly), 1'b1, "random");
    end
  endtask

  initial begin
    mem_load_type = 3'b000; mem_store_type = 2'b00; addr = 32'h0; wdata = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_priority();
    test_stray_ack();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus-ack watchdog limit in cycles (1..255).
REQ-002 SHALL have ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 mem_read  in  1  MEM-stage load request from decoder
 mem_write  in  1  MEM-stage store request from decoder
 mem_load_type  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
 mem_store_type  in  2  00 SB, 01 SH, 10 SW
 addr  in  32  effective byte address
 wdata  in  32  store data, right-justified
 stall  out  1  hold pipeline
 rdata  out  32  extended load result
 rdata_valid  out  1  one-cycle strobe, load result valid
 misaligned  out  1  one-cycle strobe, access rejected
 bus_err  out  1  one-cycle strobe, watchdog expired
 bus_req  out  1  bus request, held until bus_ack
 bus_we  out  1  1 = write
 bus_addr  out  32  word address, {addr[31:2],2'b00}
 bus_be  out  4  byte enables
 bus_wdata  out  32  lane-replicated store data
 bus_ack  in  1  bus completion, single cycle
 bus_rdata  in  32  read word, valid with bus_ack

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-004 IDLE: mem_read|mem_write high -> stall=1 combinationally same cycle; aligned -> BUSY, misaligned -> DONE.
REQ-005 mem_write SHALL take priority when mem_read and mem_write are both high.
REQ-006 Load types 101-111 SHALL act as LW; store type 11 SHALL act as SW.
REQ-007 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00; no bus_req issued.
REQ-008 BUSY: bus_req=1, bus fields registered on entry and stable until bus_ack; stall=1.
REQ-009 BUSY + bus_ack -> DONE; bus_rdata captured that cycle.
REQ-010 BUSY: watchdog counts cycles; reaching TIMEOUT_CYCLES without bus_ack -> drop bus_req, DONE with bus_err.
REQ-011 DONE: lasts exactly one cycle, stall=0, exactly one of rdata_valid (loads), misaligned, bus_err, or none (successful store) asserted; -> IDLE.
REQ-012 bus_be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; loads same pattern per width.
REQ-013 bus_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-014 rdata: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-015 rdata SHALL be 0 except during load DONE cycle.
REQ-016 Minimum latency: aligned access with bus_ack in first BUSY cycle -> DONE 2 cycles after request.
REQ-017 bus_ack outside BUSY SHALL be ignored.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, counter 0, and all outputs 0, including mid-BUSY (bus_req dropped).
REQ-019 First request accepted on first rising edge after rst_n deasserts.

Structure
REQ-020 Load/store type encodings and FSM state encodings SHALL live in the shared core package alongside the decoder encodings.
REQ-021 Load extraction/extension SHALL be one combinational sub-module, load_align_ext.

Verification
REQ-022 SB addr=0x1003 wdata=0xAB, ack after 1 cycle -> bus_addr 0x1000, be 1000, wdata 0xABABABAB, stall low in DONE.
REQ-023 LB addr=0x2001, bus_rdata 0x0000_80FF -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-024 LH addr=0x2002, bus_rdata 0x8001_0000 -> rdata 0xFFFF8001, be 1100.
REQ-025 LW addr=0x3002 -> misaligned one cycle, no bus_req, stall 1 cycle.
REQ-026 SW, bus_ack never asserted -> bus_err after 255 BUSY cycles, bus_req low, return to IDLE.
REQ-027 rst_n low mid-BUSY -> bus_req, stall 0 immediately; late bus_ack after reset ignored.
